// File: rtl/otter_mmio_hub.sv
// Memory-mapped I/O hub for the OTTER IOBUS: synchronised input ports, registered
// output ports and per-input change-detect interrupts with W1C status and mask.
module otter_mmio_hub #(
    parameter int unsigned N_IN        = 2,
    parameter int unsigned N_OUT       = 3,
    parameter int unsigned DATA_W      = 16,
    parameter logic [31:0] BASE_IN     = 32'h1100_0000,
    parameter logic [31:0] BASE_OUT    = 32'h1100_0020,
    parameter logic [31:0] STRIDE      = 32'h20,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [31:0]              IOBUS_ADDR,
    input  logic [31:0]              IOBUS_OUT,
    input  logic                     IOBUS_WR,
    output logic [31:0]              IOBUS_IN,
    input  logic [N_IN*DATA_W-1:0]   IN_PORTS,
    output logic [N_OUT*DATA_W-1:0]  OUT_PORTS,
    output logic                     CPU_INTR
);

    localparam logic [31:0] IRQ_STAT_AD = BASE_IN + 32'(N_IN) * STRIDE;
    localparam logic [31:0] IRQ_MASK_AD = IRQ_STAT_AD + STRIDE;
    localparam int unsigned ARM_CYC     = SYNC_STAGES + 1;
    localparam int unsigned ARM_W       = $clog2(ARM_CYC + 1);

    logic [SYNC_STAGES-1:0][N_IN*DATA_W-1:0] sync_q;
    logic [N_IN*DATA_W-1:0]  s, prev_q;
    logic [N_IN-1:0]         chg, w1c, stat_q, stat_d, mask_q, mask_d;
    logic [N_OUT*DATA_W-1:0] out_q, out_d;
    logic [ARM_W-1:0]        arm_q, arm_d;
    logic                    armed, intr_q, wr_stat, wr_mask;
    logic                    unused_wdata;

    assign s            = sync_q[SYNC_STAGES-1];
    assign armed        = (arm_q == ARM_W'(ARM_CYC));
    assign arm_d        = armed ? arm_q : arm_q + ARM_W'(1);
    assign wr_stat      = IOBUS_WR && (IOBUS_ADDR == IRQ_STAT_AD);
    assign wr_mask      = IOBUS_WR && (IOBUS_ADDR == IRQ_MASK_AD);
    assign unused_wdata = ^IOBUS_OUT;

    always_comb begin
        chg = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            chg[k] = armed && (s[k*DATA_W +: DATA_W] != prev_q[k*DATA_W +: DATA_W]);
        end
    end

    // A change in the same cycle as a W1C keeps the bit set.
    always_comb begin
        w1c    = wr_stat ? IOBUS_OUT[N_IN-1:0] : '0;
        stat_d = (stat_q & ~w1c) | chg;
        mask_d = wr_mask ? IOBUS_OUT[N_IN-1:0] : mask_q;
    end

    // Output and IRQ registers may share addresses; every exact match is written.
    always_comb begin
        out_d = out_q;
        if (IOBUS_WR) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                if (IOBUS_ADDR == BASE_OUT + 32'(k) * STRIDE) begin
                    out_d[k*DATA_W +: DATA_W] = IOBUS_OUT[DATA_W-1:0];
                end
            end
        end
    end

    always_comb begin
        IOBUS_IN = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (IOBUS_ADDR == BASE_IN + 32'(k) * STRIDE) begin
                IOBUS_IN = 32'(s[k*DATA_W +: DATA_W]);
            end
        end
        if (IOBUS_ADDR == IRQ_STAT_AD) IOBUS_IN = 32'(stat_q);
        if (IOBUS_ADDR == IRQ_MASK_AD) IOBUS_IN = 32'(mask_q);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
            prev_q <= '0;
            arm_q  <= '0;
            stat_q <= '0;
            mask_q <= '0;
            out_q  <= '0;
            intr_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], IN_PORTS};
            prev_q <= s;
            arm_q  <= arm_d;
            stat_q <= stat_d;
            mask_q <= mask_d;
            out_q  <= out_d;
            intr_q <= |(stat_q & mask_q);
        end
    end

    assign OUT_PORTS = out_q;
    assign CPU_INTR  = intr_q;

    a_no_x: assert property (@(posedge CLK) disable iff (!RST_N)
        !$isunknown({IOBUS_IN, OUT_PORTS, CPU_INTR}));
    a_mask_gates_intr: assert property (@(posedge CLK) disable iff (!RST_N)
        (mask_q == '0) |=> !CPU_INTR);

endmodule

// File: tb/tb_otter_mmio_hub.sv
// Directed bench for otter_mmio_hub at default parameters: reset, port I/O,
// interrupt timing, set/clear collision, masking and reset during a write.
module tb_otter_mmio_hub;

    localparam logic [31:0] IN0  = 32'h1100_0000;
    localparam logic [31:0] IN1  = 32'h1100_0020;
    localparam logic [31:0] OUT0 = 32'h1100_0020;
    localparam logic [31:0] STAT = 32'h1100_0040;
    localparam logic [31:0] MASK = 32'h1100_0060;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;
    logic        IOBUS_WR;
    logic [31:0] IN_PORTS;
    logic [47:0] OUT_PORTS;
    logic        CPU_INTR;

    int n_assert = 0;
    int n_fail   = 0;

    otter_mmio_hub #(
        .N_IN(2), .N_OUT(3), .DATA_W(16),
        .BASE_IN(32'h1100_0000), .BASE_OUT(32'h1100_0020), .STRIDE(32'h20),
        .SYNC_STAGES(2)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
        .IOBUS_IN(IOBUS_IN), .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS),
        .CPU_INTR(CPU_INTR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        IOBUS_ADDR = addr;
        #1;
        check(tag, {32'h0, IOBUS_IN}, {32'h0, exp});
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        step();
        IOBUS_WR   = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0; IN_PORTS = '0;

        // 1: reset with inputs toggling, then release
        for (int i = 0; i < 4; i++) begin
            step();
            IN_PORTS = (i % 2 == 0) ? 32'hFFFF_A5A5 : 32'h1234_0F0F;
        end
        check("rst_out", OUT_PORTS, 48'h0);
        check("rst_intr", CPU_INTR, 1'b0);
        IN_PORTS = {16'h00F0, 16'h0000};
        RST_N = 1'b1;
        rd("sync_c0", IN1, 32'h0);
        step();
        rd("sync_c1", IN1, 32'h0);
        step();
        rd("sync_c2", IN1, 32'h0000_00F0);
        repeat (4) step();
        rd("rst_stat", STAT, 32'h0);
        check("rst_intr2", CPU_INTR, 1'b0);
        check("rst_out2", OUT_PORTS, 48'h0);

        // 2: output writes
        wr(OUT0, 32'h0000_1111);
        wr(MASK, 32'h0000_2220);
        IOBUS_ADDR = STAT; IOBUS_OUT = 32'hABCD_1234; IOBUS_WR = 1'b1;
        #1;
        check("out_prewr", OUT_PORTS, 48'h2220_0000_1111);
        step();
        IOBUS_WR = 1'b0;
        check("out_wr1", OUT_PORTS, 48'h2220_1234_1111);
        wr(32'h1100_0044, 32'hFFFF_FFFF);
        check("out_unmapped", OUT_PORTS, 48'h2220_1234_1111);
        rd("mask_zero", MASK, 32'h0);

        // 3: input read latency
        IN_PORTS = {16'h00F0, 16'h5A5A};
        rd("in_t0", IN0, 32'h0);
        step();
        rd("in_t1", IN0, 32'h0);
        step();
        rd("in_t2", IN0, 32'h0000_5A5A);
        rd("rd_unmapped", 32'h1100_0010, 32'h0);
        rd("stat_t2", STAT, 32'h0);
        step();
        rd("stat_t3", STAT, 32'h1);
        check("intr_masked_t3", CPU_INTR, 1'b0);
        step();
        check("intr_masked_t4", CPU_INTR, 1'b0);
        wr(STAT, 32'h1);
        rd("stat_clr", STAT, 32'h0);

        // 4: interrupt timing
        wr(MASK, 32'h1);
        IN_PORTS = {16'h00F0, 16'hA5A5};
        step(); step();
        rd("irq_stat_t2", STAT, 32'h0);
        step();
        rd("irq_stat_t3", STAT, 32'h1);
        check("irq_intr_t3", CPU_INTR, 1'b0);
        step();
        check("irq_intr_t4", CPU_INTR, 1'b1);
        wr(STAT, 32'h1);
        rd("w1c_stat", STAT, 32'h0);
        check("w1c_intr_hold", CPU_INTR, 1'b1);
        step();
        check("w1c_intr_fall", CPU_INTR, 1'b0);

        // 5: W1C collides with a fresh change
        IN_PORTS = {16'h00F0, 16'h1234};
        repeat (4) step();
        check("col_intr_pre", CPU_INTR, 1'b1);
        IN_PORTS = {16'h00F0, 16'h4321};
        step(); step();
        wr(STAT, 32'h1);
        rd("col_stat", STAT, 32'h1);
        check("col_intr0", CPU_INTR, 1'b1);
        step();
        check("col_intr1", CPU_INTR, 1'b1);

        // 6: masking, then reset in the middle of a write
        wr(MASK, 32'h2);
        IN_PORTS = {16'h0F00, 16'h4321};
        repeat (3) step();
        rd("m_stat3", STAT, 32'h3);
        step();
        check("m_intr", CPU_INTR, 1'b1);
        wr(STAT, 32'h2);
        rd("m_stat1", STAT, 32'h1);
        rd("m_mask", MASK, 32'h2);
        step();
        check("m_intr_off", CPU_INTR, 1'b0);
        wr(MASK, 32'h3);
        step();
        check("m_intr_on", CPU_INTR, 1'b1);
        check("m_out", OUT_PORTS, 48'h0003_0002_1111);

        IOBUS_ADDR = OUT0; IOBUS_OUT = 32'h0000_BEEF; IOBUS_WR = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        check("ar_out", OUT_PORTS, 48'h0);
        check("ar_intr", CPU_INTR, 1'b0);
        check("ar_iobus", {32'h0, IOBUS_IN}, 64'h0);
        step();
        IOBUS_WR = 1'b0;
        RST_N = 1'b1;
        check("ar_wr_lost", OUT_PORTS, 48'h0);
        rd("ar_stat", STAT, 32'h0);
        rd("ar_mask", MASK, 32'h0);
        repeat (6) step();
        rd("ar_stat_arm", STAT, 32'h0);
        rd("ar_in0", IN0, 32'h0000_4321);
        check("ar_intr2", CPU_INTR, 1'b0);
        check("ar_out2", OUT_PORTS, 48'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
